// File: rtl/demux_scheduler_if.sv
// Bundle of the demux scheduler's handshake, data and status signals.
// The master side feeds words in and supplies per-port readiness; the
// slave side is the scheduler itself.
interface demux_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int PORTS = 4,
    parameter int DW    = $clog2(PORTS)
);
    logic             MODE;
    logic             IN_VALID;
    logic [WIDTH-1:0] IN_DATA;
    logic [DW-1:0]    IN_DEST;
    logic             IN_READY;
    logic [PORTS-1:0] OUT_VALID;
    logic [WIDTH-1:0] OUT_DATA;
    logic [PORTS-1:0] OUT_READY;
    logic             BUSY;
    logic [DW-1:0]    RR_PTR;

    modport master (
        output MODE, IN_VALID, IN_DATA, IN_DEST, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, BUSY, RR_PTR
    );

    modport slave (
        input  MODE, IN_VALID, IN_DATA, IN_DEST, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, BUSY, RR_PTR
    );
endinterface

// File: rtl/demux_scheduler.sv
// Single-slot demultiplexer: holds one word and offers it to exactly one
// output port, chosen either by the sender (directed) or by a round-robin
// pointer that advances after BURST words. Delivery is strictly in order.
module demux_scheduler #(
    parameter int WIDTH = 8,
    parameter int PORTS = 4,
    parameter int BURST = 2
) (
    input  logic           CLK,
    input  logic           RST,
    demux_scheduler_if.slave bus
);
    localparam int DW = $clog2(PORTS);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [PORTS-1:0] r_out_valid;
    logic [DW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_burst_cnt;

    logic             w_fire;
    logic             w_in_ready;
    logic             w_accept;
    logic [DW-1:0]    w_dest;
    logic [CW-1:0]    w_cnt_next;

    // A fire needs the addressed port's ready; other ports' ready bits are
    // masked out by the one-hot valid.
    assign w_fire     = (r_state == FULL) && |(r_out_valid & bus.OUT_READY);
    assign w_in_ready = !RST && ((r_state == EMPTY) || w_fire);
    assign w_accept   = bus.IN_VALID && w_in_ready;
    assign w_dest     = bus.MODE ? r_rr_ptr : bus.IN_DEST;
    assign w_cnt_next = r_burst_cnt + CW'(1);

    // Slot state, held word/destination and round-robin bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= EMPTY;
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_state     <= FULL;
                r_out_data  <= bus.IN_DATA;
                r_out_valid <= PORTS'(1) << w_dest;
                if (bus.MODE) begin
                    if (w_cnt_next == CW'(BURST)) begin
                        r_burst_cnt <= '0;
                        r_rr_ptr    <= r_rr_ptr + DW'(1);
                    end else begin
                        r_burst_cnt <= w_cnt_next;
                    end
                end
            end else if (w_fire) begin
                r_state     <= EMPTY;
                r_out_valid <= '0;
            end
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT_DATA  = r_out_data;
    assign bus.BUSY      = (r_state == FULL);
    assign bus.RR_PTR    = r_rr_ptr;
endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8, data word width in bits.
- PORTS, default 4, number of output ports; power of 2, minimum 2.
- BURST, default 2, words sent to one port before the round-robin pointer advances; minimum 1.
- DW = log2(PORTS), derived.

REQ-002 Ports SHALL be:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- MODE  in  1  0 = directed (IN_DEST selects the port), 1 = round-robin.
- IN_VALID  in  1  input word present.
- IN_DATA  in  WIDTH  input word.
- IN_DEST  in  DW  destination port; used only when MODE=0.
- IN_READY  out  1  block accepts a word this cycle.
- OUT_VALID  out  PORTS  one-hot; bit i set means a word is offered to port i.
- OUT_DATA  out  WIDTH  held word, broadcast to all ports.
- OUT_READY  in  PORTS  bit i set means port i accepts.
- BUSY  out  1  a word is held.
- RR_PTR  out  DW  current round-robin port.

Function
REQ-003 The block SHALL hold at most one word in a registered output slot with state EMPTY or FULL; BUSY SHALL be 1 exactly in FULL.
- REQ-004 An input accept SHALL occur when IN_VALID=1 and IN_READY=1.
- REQ-005 An output fire SHALL occur when OUT_VALID[i]=1 and OUT_READY[i]=1 for the held port i.
- REQ-006 IN_READY SHALL equal !RST and (EMPTY or output fire this cycle); IN_READY is combinational on OUT_READY.
- REQ-007 OUT_VALID[i] SHALL be 1 only in FULL and only for i equal to the held destination; all other bits SHALL be 0.
- REQ-008 OUT_READY bits of non-addressed ports SHALL be ignored.
- REQ-009 Latency: a word accepted at edge N SHALL appear on OUT_DATA/OUT_VALID from N+1.
- REQ-010 Sustained throughput SHALL be one word per cycle when the addressed port holds OUT_READY=1.

REQ-011 State transitions SHALL be:
- EMPTY + accept -> FULL.
- FULL + fire + no accept -> EMPTY.
- FULL + fire + accept -> FULL with the new word loaded.
- FULL + no fire -> FULL, with OUT_DATA and OUT_VALID held stable.

REQ-012 Destination SHALL be captured at accept time: IN_DEST when MODE=0, RR_PTR when MODE=1. MODE SHALL be sampled only on accept; a held word keeps its destination across MODE changes.

REQ-013 In MODE=1 each accept SHALL increment a burst counter (width log2(BURST)+1):
- On reaching BURST, the counter SHALL clear and RR_PTR SHALL advance by 1 modulo PORTS (PORTS-1 wraps to 0).

REQ-014 In MODE=0, RR_PTR and the burst counter SHALL hold their values.
REQ-015 No word SHALL be dropped or duplicated; IN_DATA SHALL be ignored when no accept occurs.
REQ-016 A port stalling with OUT_READY=0 SHALL block all traffic, including words for other ports (strict in-order delivery).

Reset
REQ-017 While RST=1 at an edge, the block SHALL set: state EMPTY, BUSY=0, OUT_VALID=0, OUT_DATA=0, RR_PTR=0, burst counter=0.
REQ-018 IN_READY SHALL be 0 while RST=1.
REQ-019 A held word SHALL be discarded by reset mid-operation, and no OUT_VALID SHALL be asserted in the cycle after reset.
REQ-020 The first accept after reset in MODE=1 SHALL target port 0.

Verification
REQ-021 Directed: MODE=0, send 0x11/dest 2, 0x22/dest 0, 0x33/dest 3 back-to-back with all OUT_READY=1 -> OUT_VALID = 0100, 0001, 1000 on consecutive cycles carrying 0x11, 0x22, 0x33; IN_READY stays 1.
REQ-022 Round-robin: MODE=1, BURST=2, 10 words 0x00-0x09 -> ports 0,0,1,1,2,2,3,3,0,0; RR_PTR wraps 3 -> 0 after word 0x07.
REQ-023 Backpressure: word 0xA5 to port 1 with OUT_READY[1]=0 for 5 cycles -> OUT_DATA=0xA5 and OUT_VALID=0010 stable, IN_READY=0 and BUSY=1 throughout. Raising OUT_READY[1] -> fire, and the next word is accepted in the same cycle.
REQ-024 Reset mid-operation: RST during FULL holding 0x5A -> next cycle OUT_VALID=0, OUT_DATA=0, BUSY=0, RR_PTR=0; 0x5A never delivered.
REQ-025 Mode switch: MODE=1 with RR_PTR=2 and counter=1, switch to MODE=0 and send 2 words to dest 3 -> RR_PTR stays 2; back to MODE=1, the next word goes to port 2 and then RR_PTR advances to 3.
REQ-026 Ignored readiness: held word for port 0 with OUT_READY=1110 -> no fire, word held.
